acc_feeder: RTL and testbench
=============================

Name: acc_feeder

Overview:
- Upstream sequencer for the accumulator core.
- On a start pulse it:
  - clears the accumulator with a one-cycle run pulse;
  - streams N operands from a synchronous read memory into the accumulator's number/valid inputs;
  - counts the accumulator's valid returns and captures the final sum.
- Sits between the memory and the accumulator core. It gives the top level a single start/busy/done handshake per accumulation job.

Parameters:
- IN_DATA_WIDTH, 8, operand width; matches the accumulator input width.
- DWIDTH, 16, result width; matches the accumulator result width.
- AWIDTH, 8, memory address width. Maximum job length is 2^AWIDTH words.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start_i  input  1  job start pulse; sampled only in IDLE.
- num_cnt_i  input  AWIDTH+1  job length N; latched on accepted start.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle pulse when result_o is updated.
- result_o  output  DWIDTH  captured sum of the last completed job.
- mem_ce_o  output  1  memory read enable.
- mem_addr_o  output  AWIDTH  memory read address.
- mem_q_i  input  IN_DATA_WIDTH  memory read data, valid 1 cycle after mem_ce_o.
- acc_run_o  output  1  accumulator clear pulse.
- acc_number_o  output  IN_DATA_WIDTH  operand to the accumulator; equals mem_q_i combinationally.
- acc_valid_o  output  1  operand valid; mem_ce_o delayed by one register.
- acc_valid_i  input  1  accumulator result-valid tick.
- acc_result_i  input  DWIDTH  accumulator running result.

Behaviour:
- Reset: state=IDLE. busy_o, done_o, mem_ce_o, acc_run_o and acc_valid_o are 0. mem_addr_o=0, result_o=0, all counters 0.
- Reset mid-job: abandons the job immediately. result_o returns to 0.
- FSM states: IDLE, CLEAR, FETCH, DRAIN, DONE.
- IDLE:
  - start_i=1: latch N = min(num_cnt_i, 2^AWIDTH), go to CLEAR.
  - start_i is ignored in all other states. There is no queueing.
- CLEAR:
  - acc_run_o=1 for exactly this cycle.
  - Reset the issue counter and return counter.
  - N=0: go to DONE with result_o <= 0.
  - N>0: go to FETCH.
- FETCH:
  - mem_ce_o=1 each cycle; mem_addr_o = issue counter, starting at 0.
  - Issue counter increments per cycle.
  - After issuing address N-1, go to DRAIN.
  - mem_ce_o is 0 outside FETCH.
- acc_valid_o: registered copy of mem_ce_o, so it aligns with mem_q_i. It is high for exactly N cycles per job.
- Return counter: increments on every acc_valid_i=1 sampled in FETCH or DRAIN.
- Capture: on the edge where the N-th acc_valid_i is sampled:
  - result_o <= acc_result_i;
  - go to DONE.
  - This edge may occur in DRAIN, or in FETCH only if the pipeline shortens. Both cases are handled identically.
- DONE: done_o=1 for one cycle, then go to IDLE. result_o holds until the next capture.
- Latency, with start sampled at edge 0:
  - acc_run_o in cycle 1;
  - addresses in cycles 2..N+1;
  - acc_valid_o in cycles 3..N+2;
  - done_o in cycle N+4, assuming the accumulator has 1-cycle latency.
  - For N=0, done_o is in cycle 2.
- Back-to-back jobs: a start_i in the cycle after done_o (IDLE) is accepted. Minimum job period is N+5 cycles.
- Arithmetic: summation is performed by the accumulator; wrap-around modulo 2^DWIDTH is passed through unchanged. Internal counters are AWIDTH+1 bits wide, so N=2^AWIDTH issues addresses 0..2^AWIDTH-1 with no address wrap inside a job.

Optional Feature:
ACC_FEEDER_ABORT_EN
- Defined:
  - Adds input port abort_i (1 bit).
  - abort_i=1 in any non-IDLE state forces IDLE on the next edge.
  - mem_ce_o and acc_valid_o drop in that same next cycle.
  - No done_o; result_o is unchanged.
  - abort_i in IDLE has no effect.
  - abort_i and start_i together in IDLE: start wins.
- Undefined: port absent; jobs always run to completion.

Test Plan:
- mem[0..3]={1,2,3,4}, start with num_cnt_i=4 -> acc_run_o in cycle 1, mem_addr_o 0,1,2,3 in cycles 2-5, done_o in cycle 8, result_o=10, busy_o high in cycles 1-8.
- num_cnt_i=0 -> acc_run_o in cycle 1, done_o in cycle 2, result_o=0, mem_ce_o never asserted.
- num_cnt_i=300 with AWIDTH=8 and mem all 0xFF -> clamped to 256 reads, mem_addr_o ends at 255, result_o=65280, done_o in cycle 260.
- Job N=2 {5,6} then start_i re-pulsed during busy, then a new job N=1 {9} started the cycle after done_o -> mid-job start ignored; first result 11, second result 9. Accumulator was cleared between jobs, so the second result is not 20.
- reset_n asserted low in cycle 4 of an N=4 job -> all outputs at reset values asynchronously. After release, there is no done_o until a new start.
- (ACC_FEEDER_ABORT_EN) abort_i in cycle 3 of an N=4 job -> IDLE at cycle 4, mem_ce_o=0 at cycle 4, no done_o, result_o keeps its previous value.

Source files
------------

// File: rtl/acc_feeder_if.sv
// Memory-read and accumulator-core bus used by acc_feeder.
// master: the feeder side. slave: the memory and accumulator side.
interface acc_feeder_if #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int DWIDTH        = 16,
  parameter int AWIDTH        = 8
);
  // synchronous-read memory port
  logic                     mem_ce_o;
  logic [AWIDTH-1:0]        mem_addr_o;
  logic [IN_DATA_WIDTH-1:0] mem_q_i;

  // accumulator core port
  logic                     acc_run_o;
  logic [IN_DATA_WIDTH-1:0] acc_number_o;
  logic                     acc_valid_o;
  logic                     acc_valid_i;
  logic [DWIDTH-1:0]        acc_result_i;

  modport master (
    output mem_ce_o, mem_addr_o, acc_run_o, acc_number_o, acc_valid_o,
    input  mem_q_i, acc_valid_i, acc_result_i
  );

  modport slave (
    input  mem_ce_o, mem_addr_o, acc_run_o, acc_number_o, acc_valid_o,
    output mem_q_i, acc_valid_i, acc_result_i
  );
endinterface

// File: rtl/acc_feeder.sv
// acc_feeder: sequences one accumulation job per start pulse.
// Clears the accumulator, streams N words from a synchronous-read memory into
// it, counts the returned valid ticks and captures the final sum.
// Optional feature macro: ACC_FEEDER_ABORT_EN (adds abort_i, forces IDLE).
module acc_feeder #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int DWIDTH        = 16,
  parameter int AWIDTH        = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [AWIDTH:0]   num_cnt_i,
`ifdef ACC_FEEDER_ABORT_EN
  input  logic              abort_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic [DWIDTH-1:0] result_o,
  acc_feeder_if.master      bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, DONE} state_t;

  // Largest job is 2^AWIDTH words; counters carry one extra bit so that
  // length is representable and addresses never wrap inside a job.
  localparam logic [AWIDTH:0] MAX_N = {1'b1, {AWIDTH{1'b0}}};

  state_t            state_reg, state_next;
  logic [AWIDTH:0]   n_reg, n_next;
  logic [AWIDTH:0]   issue_reg, issue_next;
  logic [AWIDTH:0]   ret_reg, ret_next;
  logic [DWIDTH-1:0] result_reg, result_next;
  logic              acc_valid_reg;
  logic              mem_ce;
  logic              acc_run;
  logic              busy;
  logic              done;
  logic              abort;

`ifdef ACC_FEEDER_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // Next-state, counter updates and Moore outputs for the job sequencer
  always_comb begin
    state_next  = state_reg;
    n_next      = n_reg;
    issue_next  = issue_reg;
    ret_next    = ret_reg;
    result_next = result_reg;
    busy        = 1'b1;
    done        = 1'b0;
    mem_ce      = 1'b0;
    acc_run     = 1'b0;

    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start_i) begin
          n_next     = (num_cnt_i > MAX_N) ? MAX_N : num_cnt_i;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        acc_run    = 1'b1;
        issue_next = '0;
        ret_next   = '0;
        if (n_reg == '0) begin
          result_next = '0;
          state_next  = DONE;
        end else begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        mem_ce     = 1'b1;
        issue_next = issue_reg + 1'b1;
        if (issue_reg == n_reg - 1'b1) state_next = DRAIN;
      end
      DRAIN: ;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Returns are counted in FETCH as well as DRAIN so a shorter accumulator
    // pipeline finishing during FETCH is captured the same way.
    if ((state_reg == FETCH || state_reg == DRAIN) && bus.acc_valid_i) begin
      ret_next = ret_reg + 1'b1;
      if (ret_reg == n_reg - 1'b1) begin
        result_next = bus.acc_result_i;
        state_next  = DONE;
      end
    end

    // Abort wins over everything except an idle feeder; the sum is left alone.
    if (abort && state_reg != IDLE) begin
      state_next  = IDLE;
      result_next = result_reg;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Job length, issue/return counters and captured result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_reg      <= '0;
      issue_reg  <= '0;
      ret_reg    <= '0;
      result_reg <= '0;
    end else begin
      n_reg      <= n_next;
      issue_reg  <= issue_next;
      ret_reg    <= ret_next;
      result_reg <= result_next;
    end
  end

  // Operand-valid tracks the memory read enable by one cycle to line up with
  // mem_q_i; an abort suppresses it in the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_valid_reg <= 1'b0;
    else          acc_valid_reg <= mem_ce & ~abort;
  end

  assign busy_o           = busy;
  assign done_o           = done;
  assign result_o         = result_reg;
  assign bus.mem_ce_o     = mem_ce;
  assign bus.mem_addr_o   = issue_reg[AWIDTH-1:0];
  assign bus.acc_run_o    = acc_run;
  assign bus.acc_number_o = bus.mem_q_i;
  assign bus.acc_valid_o  = acc_valid_reg;

endmodule

// File: tb/tb_acc_feeder.sv
// Directed testbench for acc_feeder with a synchronous-read memory model and
// a one-cycle-latency accumulator model.
module tb_acc_feeder;
  localparam int IW = 8;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW:0]   num_cnt;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
`ifdef ACC_FEEDER_ABORT_EN
  logic          abort;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [IW-1:0] mem [256];
  logic [IW-1:0] mem_q;
  logic [DW-1:0] acc_sum;
  logic          acc_vld;

  acc_feeder_if #(.IN_DATA_WIDTH(IW), .DWIDTH(DW), .AWIDTH(AW)) bus ();

  acc_feeder #(.IN_DATA_WIDTH(IW), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (start),
    .num_cnt_i (num_cnt),
`ifdef ACC_FEEDER_ABORT_EN
    .abort_i   (abort),
`endif
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // synchronous-read memory
  always @(posedge clk) begin
    if (bus.mem_ce_o) mem_q <= mem[bus.mem_addr_o];
  end
  assign bus.mem_q_i = mem_q;

  // accumulator core: clear on run, add on valid, one-cycle result latency
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_sum <= '0;
      acc_vld <= 1'b0;
    end else begin
      acc_vld <= bus.acc_valid_o;
      if (bus.acc_run_o)        acc_sum <= '0;
      else if (bus.acc_valid_o) acc_sum <= acc_sum + DW'(bus.acc_number_o);
    end
  end
  assign bus.acc_valid_i  = acc_vld;
  assign bus.acc_result_i = acc_sum;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Runs one job; cycle k is the k-th cycle after the edge sampling start.
  task automatic run_job(input string tag, input int n_req, input int exp_n,
                         input int exp_done, input int exp_sum, input int repulse);
    int run_cnt = 0, run_cyc = -1, ce_cnt = 0, first_addr = -1, last_addr = -1;
    int addr_err = 0, val_cnt = 0, busy_err = 0, done_cyc = -1;
    logic [DW-1:0] res = '0;
    @(negedge clk);
    start   = 1'b1;
    num_cnt = n_req[AW:0];
    for (int k = 1; k <= exp_n + 20; k++) begin
      @(negedge clk);
      start = (k == repulse);
      if (bus.acc_run_o) begin run_cnt++; run_cyc = k; end
      if (bus.mem_ce_o) begin
        if (first_addr < 0) first_addr = k;
        if (int'(bus.mem_addr_o) != ce_cnt) addr_err++;
        last_addr = int'(bus.mem_addr_o);
        ce_cnt++;
      end
      if (bus.acc_valid_o) val_cnt++;
      if (!busy) busy_err++;
      if (done) begin done_cyc = k; res = result; break; end
    end
    start = 1'b0;
    check_val({tag, ".run_cnt"},    run_cnt, 1);
    check_val({tag, ".run_cyc"},    run_cyc, 1);
    check_val({tag, ".done_cyc"},   done_cyc, exp_done);
    check_val({tag, ".result"},     res, exp_sum);
    check_val({tag, ".ce_cnt"},     ce_cnt, exp_n);
    check_val({tag, ".valid_cnt"},  val_cnt, exp_n);
    check_val({tag, ".addr_err"},   addr_err, 0);
    check_val({tag, ".busy_err"},   busy_err, 0);
    check_val({tag, ".first_addr"}, first_addr, (exp_n == 0) ? -1 : 2);
    check_val({tag, ".last_addr"},  last_addr, exp_n - 1);
    $display("job %s: N=%0d result=%0d done_cycle=%0d", tag, n_req, res, done_cyc);
  endtask

  initial begin
    int done_cnt;
    reset_n = 1'b0;
    start   = 1'b0;
    num_cnt = '0;
`ifdef ACC_FEEDER_ABORT_EN
    abort   = 1'b0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check_val("rst.busy",   busy, 0);
    check_val("rst.done",   done, 0);
    check_val("rst.ce",     bus.mem_ce_o, 0);
    check_val("rst.run",    bus.acc_run_o, 0);
    check_val("rst.valid",  bus.acc_valid_o, 0);
    check_val("rst.addr",   bus.mem_addr_o, 0);
    check_val("rst.result", result, 0);
    reset_n = 1'b1;
    @(negedge clk);
    $display("reset released");

    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4;
    run_job("n4", 4, 4, 8, 10, -1);
    run_job("n0", 0, 0, 2, 0, -1);

    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    run_job("clamp", 300, 256, 260, 65280, -1);

    mem[0] = 8'd5; mem[1] = 8'd6;
    run_job("b2b_a", 2, 2, 6, 11, 3);
    mem[0] = 8'd9;
    run_job("b2b_b", 1, 1, 5, 9, -1);

    // reset in cycle 4 of an N=4 job
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4;
    @(negedge clk);
    start   = 1'b1;
    num_cnt = 9'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("mid.busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    check_val("mid.busy",   busy, 0);
    check_val("mid.ce",     bus.mem_ce_o, 0);
    check_val("mid.valid",  bus.acc_valid_o, 0);
    check_val("mid.run",    bus.acc_run_o, 0);
    check_val("mid.addr",   bus.mem_addr_o, 0);
    check_val("mid.result", result, 0);
    @(negedge clk);
    reset_n  = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check_val("mid.no_done", done_cnt, 0);
    $display("reset mid-job: done/busy cycles after release=%0d", done_cnt);

    run_job("after_rst", 3, 3, 7, 6, -1);

`ifdef ACC_FEEDER_ABORT_EN
    @(negedge clk);
    start   = 1'b1;
    num_cnt = 9'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort.busy",  busy, 0);
    check_val("abort.ce",    bus.mem_ce_o, 0);
    check_val("abort.valid", bus.acc_valid_o, 0);
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_val("abort.no_done", done_cnt, 0);
    check_val("abort.result",  result, 6);
    $display("abort job: done pulses=%0d result=%0d", done_cnt, result);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
